sommatore_seriale: RTL
======================

SOMMATORE_SERIALE -- requirements
Module: sommatore_seriale

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits; legal range N>=2.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  operands a, b, ripin presented.
REQ-005 SHALL have port in_ready  out  1  block can accept operands.
REQ-006 SHALL have port a  in  N  first operand, unsigned or two's complement.
REQ-007 SHALL have port b  in  N  second operand.
REQ-008 SHALL have port ripin  in  1  carry-in.
REQ-009 SHALL have port out_valid  out  1  somma/riporto hold a finished result.
REQ-010 SHALL have port out_ready  in  1  consumer takes the result.
REQ-011 SHALL have port somma  out  N  sum.
REQ-012 SHALL have port riporto  out  1  carry-out of the MSB.
REQ-013 SHALL have port overflow  out  1  signed overflow; present only when the macro is defined (REQ-030).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 In IDLE, on an edge with in_valid=1, SHALL load a and b into shift registers, the carry register with ripin, bit counter with 0, and enter CALC.
REQ-017 In CALC, each edge SHALL feed the operand LSBs plus the carry register to one full-adder bit, shift the sum bit into the MSB of the result register, shift the operands right, load the carry register with the bit's carry-out, and increment the counter.
REQ-018 SHALL enter DONE on the CALC edge where the counter equals N-1; out_valid SHALL rise exactly N edges after the acceptance edge.
REQ-019 In DONE, somma, riporto (and overflow) SHALL stay constant while out_ready=0.
REQ-020 In DONE, an edge with out_ready=1 SHALL return to IDLE; no operand is accepted on that same edge.
REQ-021 in_valid SHALL be ignored in CALC and DONE; operand changes after acceptance SHALL not affect the result.
REQ-022 somma and riporto SHALL keep the last result in IDLE until the next acceptance; their values are undefined for the consumer during CALC.
REQ-023 Arithmetic: {riporto, somma} = a + b + ripin, modulo 2^(N+1); no saturation.
REQ-024 Counter width SHALL be clog2(N), wrapping never occurs because the terminal count is N-1.

Reset
REQ-025 When reset=1 at an edge, the block SHALL enter IDLE regardless of state, aborting any CALC or DONE.
REQ-026 Reset values: out_valid=0, somma=0, riporto=0, overflow=0, carry register=0, counter=0, operand registers=0.
REQ-027 in_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-028 An aborted operation SHALL never produce out_valid=1.

Configuration
REQ-029 Macro SOMMATORE_SERIALE_OVERFLOW_EN SHALL control the overflow feature.
REQ-030 With the macro defined, overflow SHALL be the XOR of the carry into and out of the MSB bit, registered on the final CALC edge and valid with out_valid; without it the overflow port and its register SHALL not exist.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (IDLE, CALC, DONE) and the default width constant 8.
REQ-032 The single bit stage SHALL be the existing fulladder module instantiated once (riporto, somma, ripin, x1, x2); no other sub-module.

Verification (N=8)
REQ-033 a=0x0F, b=0x01, ripin=0 -> somma=0x10, riporto=0, out_valid exactly 8 edges after acceptance.
REQ-034 a=0xFF, b=0x01, ripin=0 -> somma=0x00, riporto=1, overflow=0.
REQ-035 a=0x7F, b=0x01, ripin=0 -> somma=0x80, riporto=0, overflow=1; a=0xFF, b=0xFF, ripin=1 -> somma=0xFF, riporto=1.
REQ-036 out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing a -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-037 reset asserted on the 4th CALC cycle -> out_valid never rises, all outputs 0, in_ready=1 after release; the next operation 0x03+0x04 -> 0x07.
REQ-038 Back-to-back: result taken with out_ready=1, in_valid held 1 -> next acceptance occurs one edge later in IDLE, not on the DONE edge.

Source files
------------

// File: rtl/sommatore_seriale_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package sommatore_seriale_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stato_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder, the one arithmetic stage of the serial adder.
module fulladder (
    output logic riporto,
    output logic somma,
    input  logic ripin,
    input  logic x1,
    input  logic x2
);

    assign somma   = x1 ^ x2 ^ ripin;
    assign riporto = (x1 & x2) | (ripin & (x1 ^ x2));

endmodule

// File: rtl/sommatore_seriale.sv
// Bit-serial adder: one bit per clock through a single full adder, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SOMMATORE_SERIALE_OVERFLOW_EN.
module sommatore_seriale
    import sommatore_seriale_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ripin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] somma,
`ifdef SOMMATORE_SERIALE_OVERFLOW_EN
    output logic         overflow,
`endif
    output logic         riporto
);

    localparam int CW = $clog2(N);

    stato_t         stato, stato_nx;
    logic [N-1:0]   a_sh, b_sh, s_sh;
    logic           rip;
    logic [CW-1:0]  cnt;
    logic           fa_s, fa_c;
    logic           ultimo;

    assign ultimo = (cnt == CW'(N - 1));

    fulladder u_fa (
        .riporto (fa_c),
        .somma   (fa_s),
        .ripin   (rip),
        .x1      (a_sh[0]),
        .x2      (b_sh[0])
    );

    always_ff @(posedge clock) begin
        if (reset) stato <= IDLE;
        else       stato <= stato_nx;
    end

    always_comb begin
        stato_nx  = stato;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (stato)
            IDLE: begin
                // Held low during reset so nothing is handshaken on a reset edge.
                in_ready = ~reset;
                if (in_valid) stato_nx = CALC;
            end
            CALC: begin
                if (ultimo) stato_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) stato_nx = IDLE;
            end
            default: stato_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            rip  <= 1'b0;
            cnt  <= '0;
        end else begin
            case (stato)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        rip  <= ripin;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= {fa_s, s_sh[N-1:1]};
                    rip  <= fa_c;
                    cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // After the last bit the carry register holds the MSB carry-out.
    assign somma   = s_sh;
    assign riporto = rip;

`ifdef SOMMATORE_SERIALE_OVERFLOW_EN
    logic ov_r;

    // Carry into the MSB is rip on the final bit; carry out is fa_c.
    always_ff @(posedge clock) begin
        if (reset)                       ov_r <= 1'b0;
        else if (stato == CALC && ultimo) ov_r <= rip ^ fa_c;
    end

    assign overflow = ov_r;
`endif

endmodule
